// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg
//   Shared types and constants for the 7-segment scan driver.
//   seg_t        : segment vector {a,b,c,d,e,f,g}, bit 6 = a.
//   SEG_A..SEG_G : bit position of each segment inside seg_t.
//   SEG_MASK_ALL : every segment bit set, used for polarity inversion.
//   SEG_HEX      : 16-entry hex glyph table, index = nibble value.
//   seg_decode   : nibble -> glyph lookup.
package seven_segment_pkg;

  typedef logic [6:0] seg_t;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam seg_t SEG_MASK_ALL = seg_t'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                         (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                         (1 << SEG_G));

  localparam seg_t SEG_HEX [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  function automatic seg_t seg_decode(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/seven_segment_hex_decoder.sv
// seven_segment_hex_decoder
//   Combinational hex-to-segment decoder with a dark override.
//   nibble : hex digit to show.
//   dark   : when set, all segments off regardless of nibble.
//   seg    : active-high segment pattern {a..g}.
module seven_segment_hex_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dark,
  output seg_t       seg
);

  always_comb begin
    seg = dark ? seg_t'(0) : seg_decode(nibble);
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver
//   Time-multiplexed driver for an N-digit common-electrode 7-segment
//   display. A prescaler divides clk into digit slots; each slot starts
//   with a short all-off gap to stop the previous digit ghosting into the
//   next. New content is written into a pending register and only copied
//   to the display register at a frame wrap, so a frame never mixes old
//   and new digits.
//
//   clk       : system clock, rising edge.
//   rst_n     : asynchronous active-low reset.
//   value_i   : packed hex nibbles, nibble k drives digit k (0 = rightmost).
//   dp_i      : decimal point per digit.
//   blank_i   : force digit dark (dp included).
//   lzs_i     : leading-zero suppression enable.
//   update_i  : one-cycle strobe capturing the four inputs above.
//   busy_o    : a captured update is still waiting for the frame wrap.
//   seg_o     : segments {a..g}, bit 6 = a.
//   dp_o      : decimal point.
//   dig_o     : one-hot digit enable.
//   frame_o   : one-cycle pulse at each frame start.
module seven_segment_scan_driver
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int ACTIVE_LOW_SEG = 0,
  parameter int ACTIVE_LOW_DIG = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lzs_i,
  input  logic                    update_i,
  output logic                    busy_o,
  output seg_t                    seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic                    frame_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // XOR masks turning the internal active-high view into pin polarity.
  localparam logic                  SEG_INV = (ACTIVE_LOW_SEG != 0);
  localparam seg_t                  SEG_XOR = SEG_INV ? SEG_MASK_ALL : seg_t'(0);
  localparam logic [NUM_DIGITS-1:0] DIG_XOR = (ACTIVE_LOW_DIG != 0) ?
                                              {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;

  logic [VW-1:0]         pend_value;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  pend_lzs;

  logic [VW-1:0]         disp_value;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] disp_blank;
  logic                  disp_lzs;

  logic                  tick;
  logic                  wrap;
  logic                  in_blank;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [IW-1:0]         msnz;
  logic                  dark;
  seg_t                  dec_seg;
  logic [NUM_DIGITS-1:0] dig_onehot;

  assign tick       = (presc == PRESC_LAST);
  assign wrap       = tick && (idx == IDX_LAST);
  assign in_blank   = (presc < BLANK_END);
  assign dig_onehot = NUM_DIGITS'(1) << idx;

  // Select the current digit's fields from the display register and find
  // the most-significant non-zero nibble for leading-zero suppression.
  // msnz stays 0 for an all-zero value so digit 0 always remains lit.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    msnz       = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nibble = disp_value[4*k +: 4];
        cur_dp     = disp_dp[k];
        cur_blank  = disp_blank[k];
      end
      if (disp_value[4*k +: 4] != 4'h0) begin
        msnz = IW'(k);
      end
    end
  end

  assign dark = cur_blank | (disp_lzs & (idx > msnz));

  seven_segment_hex_decoder u_decoder (
    .nibble (cur_nibble),
    .dark   (dark),
    .seg    (dec_seg)
  );

  // Slot prescaler and digit index. With a single digit the index never
  // moves and every tick is a frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Update handshake. The wrap copy uses the old pending contents; a strobe
  // in the same cycle refills pending, and since its assignment comes last
  // busy_o stays set for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_lzs   <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      disp_lzs   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      if (wrap) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
        disp_lzs   <= pend_lzs;
        busy_o     <= 1'b0;
      end
      if (update_i) begin
        pend_value <= value_i;
        pend_dp    <= dp_i;
        pend_blank <= blank_i;
        pend_lzs   <= lzs_i;
        busy_o     <= 1'b1;
      end
    end
  end

  // Registered pin drivers. Segments are also forced off during the blank
  // gap so nothing is latched onto a digit while it switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o   <= SEG_XOR;
      dp_o    <= SEG_INV;
      dig_o   <= DIG_XOR;
      frame_o <= 1'b0;
    end else begin
      frame_o <= wrap;
      if (in_blank) begin
        seg_o <= SEG_XOR;
        dp_o  <= SEG_INV;
        dig_o <= DIG_XOR;
      end else begin
        seg_o <= dec_seg ^ SEG_XOR;
        dp_o  <= (cur_dp & ~dark) ^ SEG_INV;
        dig_o <= dig_onehot ^ DIG_XOR;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb_seven_segment_scan_driver
//   Drives two copies of the scan driver (active-high and active-low pins)
//   from shared inputs and compares every cycle against a cycle-count based
//   reference model, plus directed frame captures for specific glyphs.
module tb_seven_segment_scan_driver;

  localparam int N     = 4;
  localparam int RD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = N * RD;

  localparam logic [6:0] HEX_SEGS [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blank_i = '0;
  logic        lzs_i = 1'b0;
  logic        update_i = 1'b0;

  logic        busy_o, dp_o, frame_o;
  logic [6:0]  seg_o;
  logic [3:0]  dig_o;
  logic        busy_al, dp_al, frame_al;
  logic [6:0]  seg_al;
  logic [3:0]  dig_al;

  always #5 clk = ~clk;

  seven_segment_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
    .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_DIG(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .dp_i(dp_i),
    .blank_i(blank_i), .lzs_i(lzs_i), .update_i(update_i),
    .busy_o(busy_o), .seg_o(seg_o), .dp_o(dp_o), .dig_o(dig_o),
    .frame_o(frame_o)
  );

  seven_segment_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
    .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_DIG(1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .dp_i(dp_i),
    .blank_i(blank_i), .lzs_i(lzs_i), .update_i(update_i),
    .busy_o(busy_al), .seg_o(seg_al), .dp_o(dp_al), .dig_o(dig_al),
    .frame_o(frame_al)
  );

  int testCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the scan position is derived purely from the number
  // of clock edges since reset; outputs shown after an edge describe the
  // position held before that edge.
  int          mCyc = 0;
  int          mPhase = 0;
  int          mDigit = 0;
  logic        mDark = 1'b0;
  logic [3:0]  mNib = '0;
  logic [15:0] mPendVal = '0, mDispVal = '0;
  logic [3:0]  mPendDp = '0, mPendBlank = '0, mDispDp = '0, mDispBlank = '0;
  logic        mPendLzs = 1'b0, mDispLzs = 1'b0, mBusy = 1'b0;
  logic [3:0]  eDig = '0;
  logic [6:0]  eSeg = '0;
  logic        eDp = 1'b0, eFrame = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCyc = 0;
      mPendVal = '0; mPendDp = '0; mPendBlank = '0; mPendLzs = 1'b0;
      mDispVal = '0; mDispDp = '0; mDispBlank = '0; mDispLzs = 1'b0;
      mBusy = 1'b0;
      eDig = '0; eSeg = '0; eDp = 1'b0; eFrame = 1'b0;
    end else begin
      mPhase = mCyc % RD;
      mDigit = (mCyc / RD) % N;
      eFrame = (mPhase == RD - 1) && (mDigit == N - 1);
      mNib   = 4'(mDispVal >> (4 * mDigit));
      mDark  = mDispBlank[mDigit] ||
               (mDispLzs && mDigit > 0 && (mDispVal >> (4 * mDigit)) == 0);
      eDig   = (mPhase < BC) ? 4'b0000 : 4'(1 << mDigit);
      eSeg   = mDark ? 7'b0 : HEX_SEGS[mNib];
      eDp    = mDispDp[mDigit] && !mDark;
      if (eFrame) begin
        mDispVal = mPendVal; mDispDp = mPendDp;
        mDispBlank = mPendBlank; mDispLzs = mPendLzs;
        mBusy = 1'b0;
      end
      if (update_i) begin
        mPendVal = value_i; mPendDp = dp_i;
        mPendBlank = blank_i; mPendLzs = lzs_i;
        mBusy = 1'b1;
      end
      mCyc++;
    end
  end

  // Continuous comparison; segments only matter while a digit is enabled.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("dig", dig_o, eDig);
      checkOutput("frame", frame_o, eFrame);
      checkOutput("busy", busy_o, mBusy);
      checkOutput("dig_al", dig_al, 4'(~eDig));
      checkOutput("frame_al", frame_al, eFrame);
      checkOutput("busy_al", busy_al, mBusy);
      if (eDig != 4'b0000) begin
        checkOutput("seg", seg_o, eSeg);
        checkOutput("dp", dp_o, eDp);
        checkOutput("seg_al", seg_al, 7'(~eSeg));
        checkOutput("dp_al", dp_al, !eDp);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] val, input logic [3:0] dp,
                               input logic [3:0] blank, input logic lzs);
    value_i  = val;
    dp_i     = dp;
    blank_i  = blank;
    lzs_i    = lzs;
    update_i = 1'b1;
    @(negedge clk);
    update_i = 1'b0;
  endtask

  task automatic alignTo(input int ph);
    for (int i = 0; i < 2 * FRAME && (mCyc % FRAME) != ph; i++) @(negedge clk);
  endtask

  logic [6:0] cSeg [N];
  logic       cDp  [N];
  logic [3:0] cDig [N];
  logic [6:0] cSegAl [N];
  logic [3:0] cDigAl [N];

  // Record each digit mid-slot across one full frame.
  task automatic captureFrame();
    alignTo(1);
    for (int i = 0; i < FRAME; i++) begin
      if (i % RD == 2) begin
        cSeg[i / RD]   = seg_o;
        cDp[i / RD]    = dp_o;
        cDig[i / RD]   = dig_o;
        cSegAl[i / RD] = seg_al;
        cDigAl[i / RD] = dig_al;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int frames;
    logic [15:0] rv;

    repeat (3) @(negedge clk);
    checkOutput("rst_seg", seg_o, 7'h00);
    checkOutput("rst_dig", dig_o, 4'h0);
    checkOutput("rst_dp", dp_o, 1'b0);
    checkOutput("rst_frame", frame_o, 1'b0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_seg_al", seg_al, 7'h7f);
    checkOutput("rst_dig_al", dig_al, 4'hf);
    checkOutput("rst_dp_al", dp_al, 1'b1);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset and scan
    applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0);
    checkOutput("busy_after_update", busy_o, 1'b1);
    waitCycles(FRAME + 4);
    captureFrame();
    checkOutput("s1_seg_d0", cSeg[0], 7'b0110011);
    checkOutput("s1_seg_d3", cSeg[3], 7'b0110000);
    checkOutput("s1_dig_d0", cDig[0], 4'b0001);
    checkOutput("s1_dig_d3", cDig[3], 4'b1000);
    frames = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (frame_o) frames++;
      @(negedge clk);
    end
    checkOutput("frame_count", frames, 4);

    // Leading-zero suppression
    applyStimulus(16'h0070, 4'b0000, 4'b0000, 1'b1);
    waitCycles(FRAME + 4);
    captureFrame();
    checkOutput("lzs_d3", cSeg[3], 7'b0000000);
    checkOutput("lzs_d2", cSeg[2], 7'b0000000);
    checkOutput("lzs_d1", cSeg[1], 7'b1110000);
    checkOutput("lzs_d0", cSeg[0], 7'b1111110);
    applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b1);
    waitCycles(FRAME + 4);
    captureFrame();
    checkOutput("lzs0_d3", cSeg[3], 7'b0000000);
    checkOutput("lzs0_d1", cSeg[1], 7'b0000000);
    checkOutput("lzs0_d0", cSeg[0], 7'b1111110);

    // Update races: last write wins, then update coincident with the wrap
    alignTo(5);
    applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
    waitCycles(2);
    applyStimulus(16'h2222, 4'b0000, 4'b0000, 1'b0);
    checkOutput("race_busy_set", busy_o, 1'b1);
    alignTo(1);
    checkOutput("race_busy_clear", busy_o, 1'b0);
    captureFrame();
    for (int d = 0; d < N; d++) checkOutput("race_seg", cSeg[d], 7'b1101101);
    alignTo(15);
    applyStimulus(16'h5555, 4'b0000, 4'b0000, 1'b0);
    checkOutput("wrap_busy_hold", busy_o, 1'b1);
    alignTo(8);
    checkOutput("wrap_busy_mid", busy_o, 1'b1);
    alignTo(1);
    checkOutput("wrap_busy_clear", busy_o, 1'b0);
    captureFrame();
    checkOutput("wrap_seg_d0", cSeg[0], 7'b1011011);

    // Blank and decimal point
    applyStimulus(16'h1234, 4'b0101, 4'b0100, 1'b0);
    waitCycles(FRAME + 4);
    captureFrame();
    checkOutput("blank_seg_d2", cSeg[2], 7'b0000000);
    checkOutput("blank_dp_d2", cDp[2], 1'b0);
    checkOutput("dp_d0", cDp[0], 1'b1);
    checkOutput("dp_d1", cDp[1], 1'b0);
    checkOutput("dp_d3", cDp[3], 1'b0);
    checkOutput("blank_seg_d0", cSeg[0], 7'b0110011);

    // Polarity on the active-low copy
    applyStimulus(16'h0008, 4'b0000, 4'b0000, 1'b0);
    waitCycles(FRAME + 4);
    captureFrame();
    checkOutput("al_seg_d0", cSegAl[0], 7'b0000000);
    checkOutput("al_dig_d0", cDigAl[0], 4'b1110);

    // Mid-frame reset drops the pending update
    applyStimulus(16'hABCD, 4'b1111, 4'b0000, 1'b0);
    checkOutput("mid_busy_before", busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_dig", dig_o, 4'h0);
    checkOutput("mid_rst_seg", seg_o, 7'h00);
    checkOutput("mid_rst_dp", dp_o, 1'b0);
    checkOutput("mid_rst_busy", busy_o, 1'b0);
    checkOutput("mid_rst_dig_al", dig_al, 4'hf);
    checkOutput("mid_rst_seg_al", seg_al, 7'h7f);
    checkOutput("mid_rst_busy_al", busy_al, 1'b0);
    waitCycles(3);
    #1 rst_n = 1'b1;
    waitCycles(2);
    checkOutput("post_rst_busy", busy_o, 1'b0);
    captureFrame();
    for (int d = 0; d < N; d++) checkOutput("post_rst_seg", cSeg[d], 7'b1111110);
    for (int d = 0; d < N; d++) checkOutput("post_rst_dp", cDp[d], 1'b0);

    // Random updates and live-input wiggles without a strobe
    for (int it = 0; it < 200; it++) begin
      waitCycles($urandom_range(0, 20));
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) begin
        value_i = rv;
        dp_i    = 4'($urandom);
        blank_i = 4'($urandom);
        lzs_i   = 1'($urandom);
        @(negedge clk);
      end else begin
        applyStimulus(rv, 4'($urandom), 4'($urandom & $urandom), 1'($urandom));
      end
    end
    waitCycles(2 * FRAME);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
